eoc_tohost_unit: RTL and testbench

EOC_TOHOST_UNIT -- requirements
Module: eoc_tohost_unit

---
 rtl/eoc_pkg.sv | 29 ++
 rtl/eoc_runtime_counter.sv | 56 +++++
 rtl/eoc_tohost_unit.sv | 122 ++++++++++++
 tb/tb_eoc_tohost_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/eoc_pkg.sv
// Shared register map and runtime-FSM state type for the end-of-core tohost unit.
package eoc_pkg;

  localparam logic [7:0] OFF_EXIT      = 8'h00;
  localparam logic [7:0] OFF_SIG_BEGIN = 8'h08;
  localparam logic [7:0] OFF_SIG_END   = 8'h10;
  localparam logic [7:0] OFF_RT_CTRL   = 8'h18;
  localparam logic [7:0] OFF_RUNTIME   = 8'h20;
  localparam logic [7:0] OFF_LIMIT     = 8'h28;

  typedef enum logic [1:0] {
    RT_IDLE    = 2'd0,
    RT_RUNNING = 2'd1,
    RT_DONE    = 2'd2
  } rt_state_e;

  // Replace only the bytes of old_word whose enable bit is set.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  be);
    logic [63:0] res;
    res = old_word;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/eoc_runtime_counter.sv
// Runtime measurement FSM (IDLE/RUNNING/DONE) with a saturating 64-bit cycle counter.
module eoc_runtime_counter
  import eoc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop_ctrl,
  input  logic        exit_stop,
  output rt_state_e   state,
  output logic [63:0] count,
  output logic        done
);

  rt_state_e   state_q, state_d;
  logic [63:0] count_q;
  logic        done_q;
  logic        stop;

  assign stop = stop_ctrl | exit_stop;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RT_RUNNING;
    end else if (state_q == RT_RUNNING && stop) begin
      state_d = RT_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RT_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == RT_DONE);
    end
  end

  // The stop cycle itself is not counted; a restart always wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (state_q == RT_RUNNING && !stop && count_q != '1) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign state = state_q;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: rtl/eoc_tohost_unit.sv
// Memory-mapped tohost/signature/runtime register window with a one-cycle response bus.
module eoc_tohost_unit
  import eoc_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter logic [63:0] BaseAddr  = 64'hD000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic                 err_o,
  output logic [63:0]          exit_o,
  output logic [63:0]          sig_begin_o,
  output logic [63:0]          sig_end_o,
  output logic [63:0]          runtime_o,
  output logic                 runtime_valid_o
);

  localparam logic [AddrWidth-1:0] BASE  = AddrWidth'(BaseAddr);
  localparam logic [AddrWidth-1:0] LIMIT = AddrWidth'(OFF_LIMIT);

  logic [AddrWidth-1:0] offset;
  logic [7:0]           off8;
  logic                 acc_err;
  logic                 wr_ok;
  logic                 sel_exit, sel_sig_begin, sel_sig_end, sel_rt_ctrl;
  logic [63:0]          rd_data;

  logic [63:0] exit_q, sig_begin_q, sig_end_q;

  rt_state_e   rt_state;
  logic [63:0] rt_count;
  logic        rt_done;
  logic        rt_start, rt_stop_ctrl, rt_exit_stop;

  logic        vld_p1;
  logic        err_p1;
  logic [63:0] rdata_p1;

  assign gnt_o = req_i;

  // Addresses below the base wrap to a huge offset and fall out of range.
  assign offset  = addr_i - BASE;
  assign off8    = offset[7:0];
  assign acc_err = (offset >= LIMIT) || (addr_i[2:0] != 3'b000) ||
                   (we_i && off8 == OFF_RUNTIME);
  assign wr_ok   = req_i && we_i && !acc_err;

  assign sel_exit      = (off8 == OFF_EXIT);
  assign sel_sig_begin = (off8 == OFF_SIG_BEGIN);
  assign sel_sig_end   = (off8 == OFF_SIG_END);
  assign sel_rt_ctrl   = (off8 == OFF_RT_CTRL);

  assign rt_start     = wr_ok && sel_rt_ctrl && be_i[0] &&  wdata_i[0];
  assign rt_stop_ctrl = wr_ok && sel_rt_ctrl && be_i[0] && !wdata_i[0];
  assign rt_exit_stop = wr_ok && sel_exit && !exit_q[0] && be_i[0] && wdata_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_q      <= '0;
      sig_begin_q <= '0;
      sig_end_q   <= '0;
    end else if (wr_ok) begin
      if (sel_exit && !exit_q[0]) exit_q      <= byte_merge(exit_q, wdata_i, be_i);
      if (sel_sig_begin)          sig_begin_q <= byte_merge(sig_begin_q, wdata_i, be_i);
      if (sel_sig_end)            sig_end_q   <= byte_merge(sig_end_q, wdata_i, be_i);
    end
  end

  eoc_runtime_counter u_runtime (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .start     (rt_start),
    .stop_ctrl (rt_stop_ctrl),
    .exit_stop (rt_exit_stop),
    .state     (rt_state),
    .count     (rt_count),
    .done      (rt_done)
  );

  always_comb begin
    rd_data = '0;
    case (off8)
      OFF_EXIT:      rd_data = exit_q;
      OFF_SIG_BEGIN: rd_data = sig_begin_q;
      OFF_SIG_END:   rd_data = sig_end_q;
      OFF_RT_CTRL:   rd_data = {62'b0, rt_state == RT_DONE, rt_state == RT_RUNNING};
      OFF_RUNTIME:   rd_data = rt_count;
      default:       rd_data = '0;
    endcase
  end

  // p0 -> p1: response registered one cycle after the grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= req_i;
      err_p1   <= req_i && acc_err;
      rdata_p1 <= (req_i && !we_i && !acc_err) ? rd_data : 64'd0;
    end
  end

  assign rvalid_o        = vld_p1;
  assign err_o           = err_p1;
  assign rdata_o         = rdata_p1;
  assign exit_o          = exit_q;
  assign sig_begin_o     = sig_begin_q;
  assign sig_end_o       = sig_end_q;
  assign runtime_o       = rt_count;
  assign runtime_valid_o = rt_done;

endmodule

// File: tb/tb_eoc_tohost_unit.sv
// Bench for eoc_tohost_unit: register-access vector table plus runtime/reset sequences.
module tb_eoc_tohost_unit;

  localparam logic [63:0] BASE = 64'hD000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic        gnt, rvalid, err;
  logic [63:0] rdata, exit_w, sig_begin, sig_end, runtime;
  logic        runtime_valid;

  always #5 clk = ~clk;

  eoc_tohost_unit #(.AddrWidth(64), .BaseAddr(BASE)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .be_i            (be),
    .gnt_o           (gnt),
    .rvalid_o        (rvalid),
    .rdata_o         (rdata),
    .err_o           (err),
    .exit_o          (exit_w),
    .sig_begin_o     (sig_begin),
    .sig_end_o       (sig_end),
    .runtime_o       (runtime),
    .runtime_valid_o (runtime_valid)
  );

  typedef struct {
    logic        we;
    logic [63:0] off;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    string       name;
  } resp_t;

  resp_t exp_q[$];
  vec_t  vt[17];
  int    nvec = 0;
  int    nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle bus transaction; the expected response is queued at the grant edge.
  task automatic bus(input logic bwe, input logic [63:0] off, input logic [63:0] bwdata,
                     input logic [7:0] bbe, input logic eerr, input logic [63:0] erdata,
                     input string name);
    resp_t r;
    req = 1'b1; we = bwe; addr = BASE + off; wdata = bwdata; be = bbe;
    #1 chk({name, "_gnt"}, 64'(gnt), 64'd1);
    @(posedge clk);
    r.err = eerr; r.rdata = erdata; r.name = name;
    exp_q.push_back(r);
    #1 req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    resp_t r;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        r = exp_q.pop_front();
        chk({r.name, "_err"}, 64'(err), 64'(r.err));
        chk({r.name, "_rdata"}, rdata, r.rdata);
      end
    end else if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk({r.name, "_rvalid"}, 64'd0, 64'd1);
    end
  end

  initial begin
    vt[0]  = '{1'b1, 64'h08, 64'h8000_2000, 8'hFF, 1'b0, 64'h0};
    vt[1]  = '{1'b1, 64'h10, 64'h8000_3000, 8'hFF, 1'b0, 64'h0};
    vt[2]  = '{1'b0, 64'h08, 64'h0,         8'h00, 1'b0, 64'h8000_2000};
    vt[3]  = '{1'b0, 64'h10, 64'h0,         8'h00, 1'b0, 64'h8000_3000};
    vt[4]  = '{1'b0, 64'h30, 64'h0,         8'h00, 1'b1, 64'h0};
    vt[5]  = '{1'b0, 64'h0C, 64'h0,         8'h00, 1'b1, 64'h0};
    vt[6]  = '{1'b1, 64'h20, 64'h1234,      8'hFF, 1'b1, 64'h0};
    vt[7]  = '{1'b1, 64'h28, 64'hDEAD,      8'hFF, 1'b1, 64'h0};
    vt[8]  = '{1'b1, 64'h08, 64'h1111_1111_AAAA_BBBB, 8'h0F, 1'b0, 64'h0};
    vt[9]  = '{1'b0, 64'h08, 64'h0,         8'h00, 1'b0, 64'hAAAA_BBBB};
    vt[10] = '{1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 64'h0};
    vt[11] = '{1'b0, 64'h10, 64'h0,         8'h00, 1'b0, 64'h8000_3000};
    vt[12] = '{1'b0, 64'h18, 64'h0,         8'h00, 1'b0, 64'h0};
    vt[13] = '{1'b0, 64'h20, 64'h0,         8'h00, 1'b0, 64'h0};
    vt[14] = '{1'b1, 64'h00, 64'hFFFF,      8'h01, 1'b0, 64'h0};
    vt[15] = '{1'b0, 64'h00, 64'h0,         8'h00, 1'b0, 64'hFF};
    vt[16] = '{1'b1, 64'h09, 64'h1234,      8'hFF, 1'b1, 64'h0};

    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req = 1'b1;
    #2;
    chk("rst_gnt_follows_req", 64'(gnt), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_exit", exit_w, 64'd0);
    chk("rst_runtime_valid", 64'(runtime_valid), 64'd0);
    req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 17; i++) begin
      bus(vt[i].we, vt[i].off, vt[i].wdata, vt[i].be, vt[i].exp_err, vt[i].exp_rdata,
          $sformatf("vec%0d", i));
    end
    idle(1);
    chk("tbl_sig_begin", sig_begin, 64'hAAAA_BBBB);
    chk("tbl_sig_end", sig_end, 64'h8000_3000);
    chk("tbl_exit_be01", exit_w, 64'hFF);
    chk("tbl_runtime_valid", 64'(runtime_valid), 64'd0);

    // Fresh reset so EXIT is not yet sticky for the runtime checks.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);

    bus(1'b1, 64'h08, 64'h8000_2000, 8'hFF, 1'b0, 64'h0, "sig_begin_wr");
    chk("sig_begin_out", sig_begin, 64'h8000_2000);

    bus(1'b1, 64'h18, 64'h1, 8'hFF, 1'b0, 64'h0, "rt_start");
    idle(10);
    bus(1'b1, 64'h18, 64'h0, 8'hFF, 1'b0, 64'h0, "rt_stop");
    chk("rt_count10", runtime, 64'd10);
    chk("rt_valid_done", 64'(runtime_valid), 64'd1);
    bus(1'b0, 64'h18, 64'h0, 8'h00, 1'b0, 64'h2, "rt_ctrl_done");
    bus(1'b0, 64'h20, 64'h0, 8'h00, 1'b0, 64'd10, "rt_runtime_rd");
    bus(1'b1, 64'h18, 64'h0, 8'hFF, 1'b0, 64'h0, "rt_stop_in_done");
    idle(3);
    chk("rt_count_held", runtime, 64'd10);
    chk("rt_valid_held", 64'(runtime_valid), 64'd1);

    bus(1'b1, 64'h18, 64'h1, 8'hFF, 1'b0, 64'h0, "rt_restart");
    chk("rt_valid_cleared", 64'(runtime_valid), 64'd0);
    bus(1'b0, 64'h18, 64'h0, 8'h00, 1'b0, 64'h1, "rt_ctrl_running");
    idle(3);
    bus(1'b1, 64'h00, 64'h7, 8'hFF, 1'b0, 64'h0, "exit_wr7");
    chk("exit_val7", exit_w, 64'h7);
    chk("exit_stop_valid", 64'(runtime_valid), 64'd1);
    chk("exit_stop_count", runtime, 64'd4);
    bus(1'b0, 64'h18, 64'h0, 8'h00, 1'b0, 64'h2, "rt_ctrl_exit_done");
    bus(1'b1, 64'h00, 64'h1, 8'hFF, 1'b0, 64'h0, "exit_wr1_sticky");
    chk("exit_sticky", exit_w, 64'h7);

    // Reset asserted while a read response is in flight drops that response.
    req = 1'b1; we = 1'b0; addr = BASE; be = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 1'b0; addr = '0;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    chk("mid_rst_exit", exit_w, 64'd0);
    chk("mid_rst_sig_begin", sig_begin, 64'd0);
    chk("mid_rst_runtime", runtime, 64'd0);
    chk("mid_rst_runtime_valid", 64'(runtime_valid), 64'd0);
    idle(2);
    chk("mid_rst_rvalid_later", 64'(rvalid), 64'd0);
    rst_n = 1'b1;
    idle(1);
    bus(1'b0, 64'h18, 64'h0, 8'h00, 1'b0, 64'h0, "post_rst_rt_idle");
    idle(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
